// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the cache bus arbiter: master IDs and the grant-lock states.
package cache_bus_arbiter_pkg;

   localparam logic CACHE_ARB_ID_M0 = 1'b0;
   localparam logic CACHE_ARB_ID_M1 = 1'b1;

   typedef enum logic {
      ID_M0 = CACHE_ARB_ID_M0,
      ID_M1 = CACHE_ARB_ID_M1
   } master_id_e;

   typedef enum logic {
      LOCK_FREE,
      LOCK_HELD
   } lock_state_e;

   function automatic master_id_e other_id(input master_id_e id);
      if (id == ID_M0) return ID_M1;
      return ID_M0;
   endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Avalon-MM style bus bundle; a CPU master drives it via 'master', the arbiter
// (or the cache) receives it via 'slave'.
interface cache_bus_arbiter_if;

   logic [31:0] address;
   logic [3:0]  byteEnable;
   logic        read;
   logic        write;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        waitRequest;
   logic        readDataValid;

   modport master (
      output address, byteEnable, read, write, writeData,
      input  readData, waitRequest, readDataValid
   );

   modport slave (
      input  address, byteEnable, read, write, writeData,
      output readData, waitRequest, readDataValid
   );

endinterface

// File: rtl/cache_bus_arbiter_idfifo.sv
// In-order FIFO of 1-bit master IDs, one entry per read still awaiting its
// response. Pushes when full and pops when empty are ignored.
module cache_arb_idfifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rest,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] mem_q, mem_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (do_push) mem_d[wr_ptr_q[AW-1:0]] = push_id;
   end

   always_ff @(posedge clk) begin
      if (!rest) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares the cache s0 port between m0 (fetch) and m1 (load/store) and routes
// in-order read responses back. Define CACHE_ARB_FIXED_PRIO_EN to let m1 win every tie.
module cache_bus_arbiter
   import cache_bus_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rest,
   cache_bus_arbiter_if.slave  m0,
   cache_bus_arbiter_if.slave  m1,
   cache_bus_arbiter_if.master s0,
   output logic                arb_error
);

   lock_state_e state_q, state_d;
   master_id_e  lock_id_q, lock_id_d;
   master_id_e  tie_winner, grant_id;
   logic        err_q, err_d;
   logic        req0, req1, has_grant;
   logic        g_read, g_write, blocked, fwd, accept, push, pop;
   logic        fifo_full, fifo_empty, fifo_head;
   logic [31:0] g_address, g_write_data;
   logic [3:0]  g_byte_enable;

`ifdef CACHE_ARB_FIXED_PRIO_EN
   assign tie_winner = ID_M1;
`else
   master_id_e last_q, last_d;

   // Round-robin: the master not granted on the last accepted transfer wins a tie.
   assign tie_winner = other_id(last_q);

   always_comb begin
      last_d = accept ? grant_id : last_q;
   end

   always_ff @(posedge clk) begin
      if (!rest) last_q <= ID_M1;
      else       last_q <= last_d;
   end
`endif

   always_comb begin
      req0      = m0.read | m0.write;
      req1      = m1.read | m1.write;
      has_grant = 1'b1;
      grant_id  = ID_M0;
      if (state_q == LOCK_HELD)  grant_id  = lock_id_q;
      else if (req0 && req1)     grant_id  = tie_winner;
      else if (req1)             grant_id  = ID_M1;
      else if (!req0)            has_grant = 1'b0;
   end

   // A read that would overflow the ID FIFO is held back from the cache entirely.
   always_comb begin
      if (grant_id == ID_M1) begin
         g_address     = m1.address;
         g_byte_enable = m1.byteEnable;
         g_write_data  = m1.writeData;
         g_read        = has_grant & m1.read;
         g_write       = has_grant & m1.write & ~m1.read;
      end else begin
         g_address     = m0.address;
         g_byte_enable = m0.byteEnable;
         g_write_data  = m0.writeData;
         g_read        = has_grant & m0.read;
         g_write       = has_grant & m0.write & ~m0.read;
      end
      blocked   = g_read & fifo_full;
      fwd       = rest & ~blocked & (g_read | g_write);
      accept    = fwd & ~s0.waitRequest;
      push      = accept & g_read;
      pop       = rest & s0.readDataValid & ~fifo_empty;
      state_d   = (fwd && s0.waitRequest) ? LOCK_HELD : LOCK_FREE;
      lock_id_d = fwd ? grant_id : lock_id_q;
      err_d     = err_q | (s0.readDataValid & fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (!rest) begin
         state_q   <= LOCK_FREE;
         lock_id_q <= ID_M0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         err_q     <= err_d;
      end
   end

   cache_arb_idfifo #(.DEPTH(DEPTH)) u_idfifo (
      .clk     (clk),
      .rest    (rest),
      .push    (push),
      .push_id (grant_id),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   assign s0.address    = g_address;
   assign s0.byteEnable = g_byte_enable;
   assign s0.writeData  = g_write_data;
   assign s0.read       = fwd & g_read;
   assign s0.write      = fwd & g_write;

   assign m0.waitRequest = ~rest | ((has_grant && grant_id == ID_M0) ? (s0.waitRequest | blocked) : req0);
   assign m1.waitRequest = ~rest | ((has_grant && grant_id == ID_M1) ? (s0.waitRequest | blocked) : req1);

   assign m0.readDataValid = pop & (fifo_head == ID_M0);
   assign m1.readDataValid = pop & (fifo_head == ID_M1);
   assign m0.readData      = s0.readData;
   assign m1.readData      = s0.readData;

   assign arb_error = rest & err_q;

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares the single s0 slave port of the cache between two Avalon-MM-style masters: m0 (instruction fetch) and m1 (load/store). It selects one master per transfer and holds that grant while the cache stalls. It records the master ID of every accepted read in an in-order FIFO so that each cache read response reaches the master that issued the read. The block sits between the CPU bus masters and the cache s0 port; it adds no latency on the request path.

## Interface
- DEPTH, 2: read-response ID FIFO depth, i.e. maximum reads in flight; power of two, ≥2.
- clk  in  1  system clock, all state on rising edge.
- rest  in  1  reset; synchronous, active-low.
- m0_address / m1_address  in  32  master address.
- m0_byteEnable / m1_byteEnable  in  4  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writeData / m1_writeData  in  32  write data.
- m0_readData / m1_readData  out  32  both driven directly from s0_readData.
- m0_waitRequest / m1_waitRequest  out  1  stall to master.
- m0_readDataValid / m1_readDataValid  out  1  routed read response.
- s0_address, s0_byteEnable, s0_read, s0_write, s0_writeData  out  32/4/1/1/32  selected request to cache.
- s0_readData  in  32  cache read data.
- s0_waitRequest  in  1  cache stall.
- s0_readDataValid  in  1  cache read response; responses arrive in request order.
- arb_error  out  1  sticky flag: response arrived with the ID FIFO empty.

## Operation
- A master is requesting when its read or write is high. A simultaneous read and write from one master counts as a read.
- Grant selection, combinational, used only when not locked:
  - Exactly one master requesting: that master.
  - Both requesting: round-robin, the master not granted last wins.
- Locked state:
  - The lock is set when a granted request is forwarded and s0_waitRequest=1.
  - While locked, the grant stays on the locked master regardless of the other master.
  - The lock clears in the cycle the transfer is accepted.
- Accepted transfer: granted request forwarded AND s0_waitRequest=0 AND not blocked.
  - On acceptance, the round-robin pointer records the granted ID.
- Blocked: the granted request is a read AND the FIFO is full.
  - When blocked, s0_read=0 and s0_write=0, and the granted master sees waitRequest=1.
  - No bypass: a pop in the same cycle does not unblock.
- Request outputs:
  - s0_* carries the granted master's signals.
  - With no grant: s0_read=0, s0_write=0, and the other s0 request fields are don't-care.
- waitRequest to masters:
  - Granted master: s0_waitRequest OR blocked.
  - Non-granted master with a request pending: 1.
  - Idle master: 0.
- ID FIFO:
  - Push the granted ID on every accepted read; writes do not push.
  - Pop on s0_readDataValid, and assert m{head}_readDataValid in the same cycle.
  - Push and pop in the same cycle are both allowed when not full.
  - s0_readDataValid with the FIFO empty: drop the response, set arb_error; it stays set until reset.

## Timing
- Request path: zero cycles. s0_* and m*_waitRequest are combinational from master inputs, s0_waitRequest and registered state.
- Response path: zero cycles. m*_readDataValid is combinational from s0_readDataValid and the FIFO head.
- While rest=0:
  - Outputs forced: s0_read=0, s0_write=0, m0_waitRequest=1, m1_waitRequest=1, m*_readDataValid=0, arb_error=0.
  - Registers cleared: lock=0, last-grant=m1 (so m0 wins the first tie), FIFO empty.
- Reset mid-operation: in-flight IDs are discarded. Responses arriving after reset release flag arb_error.
- Full FIFO with outstanding reads: a new read stalls until a pop is registered, i.e. one cycle after the pop.
- Back-to-back accepted transfers from alternating masters with no idle cycle are supported.

## Configuration
- CACHE_ARB_FIXED_PRIO_EN defined: m1 always wins a tie. The round-robin pointer is not implemented; locking is unchanged.
- Undefined: round-robin as specified above.

## Structure
- define.v holds `cache_arb_id_m0 (1'b0), `cache_arb_id_m1 (1'b1) and CACHE_ARB_FIXED_PRIO_EN.
- One sub-module: cache_arb_idfifo, a synchronous FIFO, width 1, depth DEPTH, with push, pop, full, empty and head.

## Test plan
- m0 read at 0x100 alone, cache responds next cycle -> s0_address=0x100 same cycle; m0_readDataValid=1 one cycle later; m1_readDataValid stays 0.
- m0 and m1 both read every cycle, no stalls -> grants alternate m0,m1,m0,…; each master receives exactly its own responses in order.
- m1 write while s0_waitRequest=1 for 3 cycles, m0 read asserted during the stall -> s0 holds the m1 write for all 3 cycles; m0 is accepted in the cycle after the write is accepted.
- DEPTH=2, two m0 reads accepted, responses withheld, third read -> s0_read=0 and m0_waitRequest=1; after the first response, the third read is accepted one cycle later.
- s0_readDataValid pulse with no reads outstanding -> no m*_readDataValid; arb_error=1 and it stays 1 until rest=0.
- With CACHE_ARB_FIXED_PRIO_EN, continuous requests from both masters -> m1 is always granted; m0 waits until m1 drops its request.
